fre_meas: RTL and testbench
===========================

# fre_meas

Waveform-width meter; receive-side counterpart to the team's `fre_divn` clock dividers. It samples an asynchronous square wave `sig_in` and measures its high width, low width and period in `clk` cycles. It publishes each completed period with a one-cycle valid strobe and a match flag against the expected divider setting. It sits on the board-test path, checking divider outputs looped back into the FPGA.

## Interface
- `CW`, 16: counter and result width in bits.
- `SYNC_STAGES`, 2: synchronizer flops on `sig_in`; minimum 2.
- `EXP_HW`, 3: expected high width in cycles.
- `EXP_LW`, 2: expected low width in cycles.
- `TOL`, 0: allowed absolute deviation per width for `match`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `sig_in`  in  1  asynchronous waveform under test.
- `meas_valid`  out  1  one-cycle strobe; results updated this cycle.
- `hi_w`  out  CW  last complete high width.
- `lo_w`  out  CW  last complete low width.
- `period`  out  CW+1  `hi_w + lo_w`.
- `match`  out  1  both widths within `TOL` of the expected values; qualified by `meas_valid`, held until the next strobe.
- `stuck`  out  1  a phase counter saturated; cleared at the next `meas_valid`.

## Operation
- **Synchronizer:** `sig_s` is the last synchronizer flop. `sig_d` is `sig_s` delayed one cycle.
- **Edge detect:** `rise = sig_s & ~sig_d`; `fall = ~sig_s & sig_d`.
- **FSM states:** WAIT_FALL (reset state), WAIT_RISE, HIGH, LOW.
- **WAIT_FALL:** on `fall`, go to WAIT_RISE. This discards a high phase that may be truncated by reset.
- **WAIT_RISE:** on `rise`, set `hi_cnt` = 1 and go to HIGH. `fall` is ignored here.
- **HIGH:**
  - While `sig_s` = 1, `hi_cnt` += 1.
  - On `fall`, latch `hi_lat` = `hi_cnt`, set `lo_cnt` = 1 and go to LOW.
  - If `hi_cnt` reaches 2^CW−1 with no fall: set `stuck`, go to WAIT_RISE, no publish.
- **LOW:**
  - While `sig_s` = 0, `lo_cnt` += 1.
  - On `rise`, publish:
    - `hi_w` = `hi_lat`, `lo_w` = `lo_cnt`, `period` = sum.
    - `match` computed; `meas_valid` = 1; `stuck` cleared.
    - Set `hi_cnt` = 1 and stay in the measuring loop (HIGH).
  - If `lo_cnt` reaches 2^CW−1 with no rise: set `stuck`, go to WAIT_RISE, no publish.
- **Arithmetic:** counters are unsigned CW bits and saturate, never wrap. `period` is CW+1 bits, so it never overflows. `match` uses the unsigned absolute difference on each width; `TOL` = 0 means exact equality.
- **Minimum widths:** one cycle high and one cycle low (in `sig_s`) are measured correctly.
- **Reset:** all outputs and flops go to 0 and the state to WAIT_FALL, immediately and asynchronously, including mid-measurement. No partial result is ever published.

## Timing
- **Reset values:** `meas_valid`, `hi_w`, `lo_w`, `period`, `match`, `stuck` are all 0.
- **Latency:** call the `clk` edge that first samples a rising `sig_in` edge 0. Then `meas_valid` is high in the cycle after edge SYNC_STAGES, for exactly one cycle.
- **First publish:** after reset, this occurs at the second `sig_in` rise following the first fall.
- **Steady state:** one strobe per input period. Strobes are at least 2 cycles apart.
- **Output registers:** all outputs are registered. `hi_w`, `lo_w`, `period` and `match` change only on a `meas_valid` cycle.
- **`stuck` timing:** `stuck` rises the cycle after saturation.

## Structure
- **Shared package `fre_pkg`:** FSM state enum, `CW` default, and `EXP_HW` / `EXP_LW` defaults shared with the divider blocks.
- **Sub-module `sync_edge`:** parameterized synchronizer plus `rise`/`fall` detector. It is reusable by other clock-domain inputs.

## Test plan
- **Steady waveform:** `sig_in` 3 high / 2 low, synchronous stimulus, 10 periods.
  - First strobe: `hi_w` = 3, `lo_w` = 2, `period` = 5, `match` = 1.
  - Strobes are exactly 5 cycles apart.
- **Reset while high:** `sig_in` high at `rst_n` release.
  - No strobe until after one fall and two rises.
  - First result is exact (no truncated high width).
- **Mismatch and tolerance:** 4 high / 2 low.
  - With `TOL` = 0: `match` = 0.
  - Rerun with `TOL` = 1: `match` = 1.
- **Minimum widths:** 1 high / 1 low.
  - `hi_w` = 1, `lo_w` = 1, `period` = 2.
  - Strobe every 2 cycles.
- **Saturation, `CW` = 4:** hold `sig_in` low 20 cycles inside LOW.
  - `stuck` = 1 after 15 counts; no strobe.
  - Then drive a 3/2 waveform: next strobe gives 3/2 and clears `stuck`.
- **Reset mid-period:** assert `rst_n` = 0 while in HIGH.
  - All outputs go to 0 asynchronously, state goes to WAIT_FALL.
  - After release, no stale values are published.

Source files
------------

// File: rtl/fre_pkg.sv
// Shared definitions for the fre_* divider and measurement blocks: defaults, FSM state
// encoding and a tolerance helper.
package fre_pkg;

  localparam int unsigned DefCw    = 16;
  localparam int unsigned DefExpHw = 3;
  localparam int unsigned DefExpLw = 2;

  typedef enum logic [1:0] {
    StWaitFall,
    StWaitRise,
    StHigh,
    StLow
  } fre_state_e;

  // Unsigned absolute difference compared against a tolerance; tol = 0 means exact.
  function automatic logic within_tol(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] tol);
    logic [31:0] diff;
    diff = (a > b) ? (a - b) : (b - a);
    return diff <= tol;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, plus registered-delay edge detect.
// SYNC_STAGES must be at least 2.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   w_sig_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_sig_s = r_sync[SYNC_STAGES-1];
  assign o_sync  = w_sig_s;
  assign o_rise  = w_sig_s & ~r_dly;
  assign o_fall  = ~w_sig_s & r_dly;

endmodule

// File: rtl/fre_meas.sv
// Waveform-width meter: measures high width, low width and period of an asynchronous
// square wave in clk cycles and flags agreement with the expected divider setting.
module fre_meas
  import fre_pkg::*;
#(
  parameter int unsigned CW          = DefCw,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EXP_HW      = DefExpHw,
  parameter int unsigned EXP_LW      = DefExpLw,
  parameter int unsigned TOL         = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig_in,
  output logic        meas_valid,
  output logic [CW-1:0] hi_w,
  output logic [CW-1:0] lo_w,
  output logic [CW:0]   period,
  output logic        match,
  output logic        stuck
);

  localparam logic [CW-1:0] CntOne = CW'(1);
  localparam logic [CW-1:0] CntMax = {CW{1'b1}};

  logic w_sig_s;
  logic w_rise;
  logic w_fall;

  fre_state_e    r_state;
  logic [CW-1:0] r_hi_cnt;
  logic [CW-1:0] r_lo_cnt;
  logic [CW-1:0] r_hi_lat;
  logic          r_valid;
  logic [CW-1:0] r_hi_w;
  logic [CW-1:0] r_lo_w;
  logic [CW:0]   r_period;
  logic          r_match;
  logic          r_stuck;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(sig_in),
    .o_sync (w_sig_s),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StWaitFall;
      r_hi_cnt <= '0;
      r_lo_cnt <= '0;
      r_hi_lat <= '0;
      r_valid  <= 1'b0;
      r_hi_w   <= '0;
      r_lo_w   <= '0;
      r_period <= '0;
      r_match  <= 1'b0;
      r_stuck  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        // A high phase in progress at reset may be truncated, so wait for a clean fall.
        StWaitFall: begin
          if (w_fall) r_state <= StWaitRise;
        end
        StWaitRise: begin
          if (w_rise) begin
            r_hi_cnt <= CntOne;
            r_state  <= StHigh;
          end
        end
        StHigh: begin
          if (w_fall) begin
            r_hi_lat <= r_hi_cnt;
            r_lo_cnt <= CntOne;
            r_state  <= StLow;
          end else if (w_sig_s) begin
            if (r_hi_cnt == CntMax) begin
              r_stuck <= 1'b1;
              r_state <= StWaitRise;
            end else begin
              r_hi_cnt <= r_hi_cnt + CntOne;
            end
          end
        end
        StLow: begin
          if (w_rise) begin
            r_valid  <= 1'b1;
            r_hi_w   <= r_hi_lat;
            r_lo_w   <= r_lo_cnt;
            r_period <= {1'b0, r_hi_lat} + {1'b0, r_lo_cnt};
            r_match  <= within_tol(32'(r_hi_lat), EXP_HW, TOL) &&
                        within_tol(32'(r_lo_cnt), EXP_LW, TOL);
            r_stuck  <= 1'b0;
            r_hi_cnt <= CntOne;
            r_state  <= StHigh;
          end else if (!w_sig_s) begin
            if (r_lo_cnt == CntMax) begin
              r_stuck <= 1'b1;
              r_state <= StWaitRise;
            end else begin
              r_lo_cnt <= r_lo_cnt + CntOne;
            end
          end
        end
        default: r_state <= StWaitFall;
      endcase
    end
  end

  assign meas_valid = r_valid;
  assign hi_w       = r_hi_w;
  assign lo_w       = r_lo_w;
  assign period     = r_period;
  assign match      = r_match;
  assign stuck      = r_stuck;

endmodule

// File: tb/tb_fre_meas.sv
// Scoreboard bench for fre_meas: three instances (default, TOL=1, CW=4) share one
// waveform; expected strobes are queued per instance and popped by a monitor.
module tb_fre_meas;

  logic clk = 1'b0;
  logic rst_n;
  logic sig_in;

  always #5 clk = ~clk;

  logic        mv0, mv1, mv2;
  logic [15:0] hw0, lw0, hw1, lw1;
  logic [3:0]  hw2, lw2;
  logic [16:0] pd0, pd1;
  logic [4:0]  pd2;
  logic        m0, m1, m2, s0, s1, s2;

  fre_meas u0 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .meas_valid(mv0), .hi_w(hw0), .lo_w(lw0),
    .period(pd0), .match(m0), .stuck(s0)
  );

  fre_meas #(.TOL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .meas_valid(mv1), .hi_w(hw1), .lo_w(lw1),
    .period(pd1), .match(m1), .stuck(s1)
  );

  fre_meas #(.CW(4)) u2 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .meas_valid(mv2), .hi_w(hw2), .lo_w(lw2),
    .period(pd2), .match(m2), .stuck(s2)
  );

  typedef struct {
    int hi;
    int lo;
    int m;
    int gap;
  } exp_t;

  exp_t sb_q [3][$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   last  [3];
  exp_t mon_e;

  logic ov [3];
  int   ohw[3], olw[3], opd[3], om[3], os[3];

  always_comb begin
    ov[0] = mv0; ohw[0] = 32'(hw0); olw[0] = 32'(lw0); opd[0] = 32'(pd0);
    om[0] = 32'(m0); os[0] = 32'(s0);
    ov[1] = mv1; ohw[1] = 32'(hw1); olw[1] = 32'(lw1); opd[1] = 32'(pd1);
    om[1] = 32'(m1); os[1] = 32'(s1);
    ov[2] = mv2; ohw[2] = 32'(hw2); olw[2] = 32'(lw2); opd[2] = 32'(pd2);
    om[2] = 32'(m2); os[2] = 32'(s2);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int d, input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d, required %0d (t=%0t)", name, d, act, req, $time);
    end
  endtask

  // Monitor: pop and compare on every strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d]) begin
          if (sb_q[d].size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_strobe dut%0d: got hi=%0d lo=%0d, required no strobe",
                     d, ohw[d], olw[d]);
          end else begin
            mon_e = sb_q[d].pop_front();
            chk(d, "hi_w", ohw[d], mon_e.hi);
            chk(d, "lo_w", olw[d], mon_e.lo);
            chk(d, "period", opd[d], mon_e.hi + mon_e.lo);
            chk(d, "match", om[d], mon_e.m);
            chk(d, "stuck_at_strobe", os[d], 0);
            if (mon_e.gap != 0) chk(d, "strobe_gap", cyc - last[d], mon_e.gap);
          end
          last[d] = cyc;
        end
      end
    end
  end

  task automatic push(input int d, input int hi, input int lo, input int m, input int gap);
    exp_t e;
    e.hi = hi; e.lo = lo; e.m = m; e.gap = gap;
    sb_q[d].push_back(e);
  endtask

  task automatic push_all(input int hi, input int lo, input int ma, input int mb, input int mc,
                          input int gap);
    push(0, hi, lo, ma, gap);
    push(1, hi, lo, mb, gap);
    push(2, hi, lo, mc, gap);
  endtask

  task automatic drive(input logic v, input int n);
    sig_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string name);
    for (int d = 0; d < 3; d++)
      chk(d, name, 32'(ov[d]) + ohw[d] + olw[d] + opd[d] + om[d] + os[d], 0);
  endtask

  task automatic chk_drained(input string name);
    for (int d = 0; d < 3; d++) chk(d, name, sb_q[d].size(), 0);
  endtask

  initial begin
    last   = '{0, 0, 0};
    rst_n  = 1'b0;
    sig_in = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    rst_n = 1'b1;

    // High at release: this truncated high and the following low are discarded.
    drive(1'b1, 4);
    drive(1'b0, 2);

    for (int i = 0; i < 10; i++) begin
      push_all(3, 2, 1, 1, 1, (i == 0) ? 0 : 5);
      drive(1'b1, 3);
      drive(1'b0, 2);
    end

    for (int i = 0; i < 3; i++) begin
      push_all(4, 2, 0, 1, 0, 6);
      drive(1'b1, 4);
      drive(1'b0, 2);
    end

    for (int i = 0; i < 4; i++) begin
      push_all(1, 1, 0, 0, 0, 2);
      drive(1'b1, 1);
      drive(1'b0, 1);
    end

    // Long low: saturates only the CW=4 instance.
    push(0, 3, 20, 0, 23);
    push(1, 3, 20, 0, 23);
    drive(1'b1, 3);
    drive(1'b0, 20);
    chk(2, "stuck_after_sat", os[2], 1);
    chk(0, "stuck_no_sat", os[0], 0);

    for (int i = 0; i < 3; i++) begin
      push(0, 3, 2, 1, 5);
      push(1, 3, 2, 1, 5);
      push(2, 3, 2, 1, (i == 0) ? 0 : 5);
      drive(1'b1, 3);
      if (i == 0) chk(2, "stuck_held", os[2], 1);
      drive(1'b0, 2);
    end
    drive(1'b1, 4);
    chk_drained("queue_before_reset");

    // Asynchronous reset in the middle of a high phase.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset_outputs");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 2);
    drive(1'b0, 2);
    for (int i = 0; i < 2; i++) begin
      push_all(3, 2, 1, 1, 1, (i == 0) ? 0 : 5);
      drive(1'b1, 3);
      drive(1'b0, 2);
    end
    drive(1'b1, 3);
    drive(1'b0, 4);
    chk_drained("queue_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
